iopage_master: RTL

//  Initiator side of the Unibus-style I/O page bus. Accepts one CPU access (read/write, word/byte) and

---
 rtl/iopage_master_pkg.sv | 36 +++
 rtl/iopage_master_timeout_ctr.sv | 31 +++
 rtl/iopage_master.sv | 135 +++++++++++++
 3 files changed

// File: rtl/iopage_master_pkg.sv
// Shared types and constants for the I/O page bus initiator.
// Holds the state encoding, bus widths, the request payload and the byte-lane helpers.
package iopage_master_pkg;

  localparam int unsigned IOPAGE_AW = 13;
  localparam int unsigned IOPAGE_DW = 16;
  localparam logic [IOPAGE_AW-1:0] IOPAGE_PSW = 13'o17776;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic                 wr;
    logic                 byte_op;
    logic [IOPAGE_AW-1:0] addr;
    logic [IOPAGE_DW-1:0] data;
  } iopage_req_t;

  // Byte writes put the low data byte on the lane picked by addr[0].
  function automatic logic [IOPAGE_DW-1:0] wr_lane(input iopage_req_t r);
    if (!r.byte_op) return r.data;
    return r.addr[0] ? {r.data[7:0], 8'h00} : {8'h00, r.data[7:0]};
  endfunction

  // Byte reads return the selected lane zero-extended; the CPU sign-extends.
  function automatic logic [IOPAGE_DW-1:0] rd_lane(input logic byte_op, input logic a0,
                                                   input logic [IOPAGE_DW-1:0] d);
    if (!byte_op) return d;
    return a0 ? {8'h00, d[15:8]} : {8'h00, d[7:0]};
  endfunction

endpackage

// File: rtl/iopage_master_timeout_ctr.sv
// Loadable down-counter bounding how long the address phase waits for a decode.
// expired_c is high while the count sits at zero.
module iopage_master_timeout_ctr #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expired_c
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)                        count_d = '0;
    else if (load)                    count_d = load_val;
    else if (en && count_q != '0)     count_d = count_q - WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expired_c = (count_q == '0);

endmodule

// File: rtl/iopage_master.sv
// I/O page bus initiator: runs one CPU access per request on the ORed slave bus and
// returns read data or a bus error (odd word address or no decode within TIMEOUT cycles).
module iopage_master
  import iopage_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 req_wr,
  input  logic                 req_byte,
  input  logic [IOPAGE_AW-1:0] req_addr,
  input  logic [IOPAGE_DW-1:0] req_data,
  output logic                 busy,
  output logic                 ack,
  output logic                 bus_err,
  output logic [IOPAGE_DW-1:0] rd_data,
  output logic [IOPAGE_AW-1:0] iopage_addr,
  output logic [IOPAGE_DW-1:0] iopage_data_out,
  output logic                 iopage_rd,
  output logic                 iopage_wr,
  output logic                 iopage_byte_op,
  input  logic [IOPAGE_DW-1:0] iopage_data_in,
  input  logic                 iopage_decode
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_e               state_q, state_d;
  iopage_req_t          req_q, req_d, in_req_c, cur_req_c;
  logic                 busy_q, busy_d, ack_q, ack_d, bus_err_q, bus_err_d;
  logic [IOPAGE_DW-1:0] rd_data_q, rd_data_d, iopage_data_out_q, iopage_data_out_d;
  logic [IOPAGE_AW-1:0] iopage_addr_q, iopage_addr_d;
  logic                 iopage_rd_q, iopage_rd_d, iopage_wr_q, iopage_wr_d;
  logic                 iopage_byte_op_q, iopage_byte_op_d;
  logic                 expired_c;

  assign in_req_c = {req_wr, req_byte, req_addr, req_data};

  // Loaded while idle so the count is fresh on entry to the address phase.
  iopage_master_timeout_ctr #(.WIDTH(CW)) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear     (state_q == ST_DONE),
    .load      (state_q == ST_IDLE),
    .load_val  (CW'(TIMEOUT - 1)),
    .en        (state_q == ST_ADDR),
    .expired_c (expired_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // A decode on the final address cycle still wins over the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (req) state_d = (!req_byte && req_addr[0]) ? ST_DONE : ST_ADDR;
      ST_ADDR:   if (iopage_decode) state_d = ST_STROBE;
                 else if (expired_c) state_d = ST_DONE;
      ST_STROBE: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so every bus signal leaves a flop.
  always_comb begin
    cur_req_c         = (state_q == ST_IDLE) ? in_req_c : req_q;
    req_d             = (state_q == ST_IDLE && req) ? in_req_c : req_q;
    busy_d            = (state_d != ST_IDLE);
    ack_d             = (state_d == ST_DONE);
    bus_err_d         = 1'b0;
    rd_data_d         = rd_data_q;
    iopage_addr_d     = '0;
    iopage_data_out_d = '0;
    iopage_byte_op_d  = 1'b0;
    iopage_rd_d       = (state_d == ST_STROBE) && !cur_req_c.wr;
    iopage_wr_d       = (state_d == ST_STROBE) && cur_req_c.wr;
    if (state_d == ST_ADDR || state_d == ST_STROBE) begin
      iopage_addr_d    = cur_req_c.addr;
      iopage_byte_op_d = cur_req_c.byte_op;
      if (cur_req_c.wr) iopage_data_out_d = wr_lane(cur_req_c);
    end
    if (state_d == ST_DONE) begin
      if (state_q == ST_STROBE) begin
        rd_data_d = cur_req_c.wr ? '0
                  : rd_lane(cur_req_c.byte_op, cur_req_c.addr[0], iopage_data_in);
      end else begin
        bus_err_d = 1'b1;
        rd_data_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q             <= '0;
      busy_q            <= 1'b0;
      ack_q             <= 1'b0;
      bus_err_q         <= 1'b0;
      rd_data_q         <= '0;
      iopage_addr_q     <= '0;
      iopage_data_out_q <= '0;
      iopage_rd_q       <= 1'b0;
      iopage_wr_q       <= 1'b0;
      iopage_byte_op_q  <= 1'b0;
    end else begin
      req_q             <= req_d;
      busy_q            <= busy_d;
      ack_q             <= ack_d;
      bus_err_q         <= bus_err_d;
      rd_data_q         <= rd_data_d;
      iopage_addr_q     <= iopage_addr_d;
      iopage_data_out_q <= iopage_data_out_d;
      iopage_rd_q       <= iopage_rd_d;
      iopage_wr_q       <= iopage_wr_d;
      iopage_byte_op_q  <= iopage_byte_op_d;
    end
  end

  assign busy            = busy_q;
  assign ack             = ack_q;
  assign bus_err         = bus_err_q;
  assign rd_data         = rd_data_q;
  assign iopage_addr     = iopage_addr_q;
  assign iopage_data_out = iopage_data_out_q;
  assign iopage_rd       = iopage_rd_q;
  assign iopage_wr       = iopage_wr_q;
  assign iopage_byte_op  = iopage_byte_op_q;

endmodule
